// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronizes and debounces active-low keys; emits level, press /
//            release pulses and the encoded index of the latest press.
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [1:0]         key_code,
    output logic               key_valid
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_FILTER   = 2'd1,
        PRESSED        = 2'd2,
        RELEASE_FILTER = 2'd3
    } state_t;

    logic [KEY_NUM-1:0] r_s1;
    logic [KEY_NUM-1:0] r_s2;
    logic [KEY_NUM-1:0] w_pressed;
    logic [1:0]         w_low_idx;

    // Synchronizer resets to the released (high) raw level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    assign w_pressed = ~r_s2;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        state_t           r_fsm;
        logic [CNT_W-1:0] r_cnt;
        logic             r_state;
        logic             r_press;
        logic             r_release;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_fsm     <= IDLE;
                r_cnt     <= '0;
                r_state   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_fsm)
                    IDLE: begin
                        if (w_pressed[i]) begin
                            r_fsm <= PRESS_FILTER;
                            r_cnt <= '0;
                        end
                    end
                    PRESS_FILTER: begin
                        if (!w_pressed[i]) begin
                            r_fsm <= IDLE;
                            r_cnt <= '0;
                        end else if (r_cnt == C_CNT_MAX) begin
                            r_fsm   <= PRESSED;
                            r_cnt   <= '0;
                            r_state <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!w_pressed[i]) begin
                            r_fsm <= RELEASE_FILTER;
                            r_cnt <= '0;
                        end
                    end
                    RELEASE_FILTER: begin
                        if (w_pressed[i]) begin
                            r_fsm <= PRESSED;
                            r_cnt <= '0;
                        end else if (r_cnt == C_CNT_MAX) begin
                            r_fsm     <= IDLE;
                            r_cnt     <= '0;
                            r_state   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_fsm <= IDLE;
                        r_cnt <= '0;
                    end
                endcase
            end
        end

        assign key_state[i]   = r_state;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;
    end

    // Lowest set index wins when several keys press together
    always_comb begin
        w_low_idx = 2'd0;
        for (int j = KEY_NUM - 1; j >= 0; j--) begin
            if (key_press[j]) begin
                w_low_idx = 2'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 2'd0;
            key_valid <= 1'b0;
        end else if (key_press != '0) begin
            key_code  <= w_low_idx;
            key_valid <= 1'b1;
        end else begin
            key_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Purpose  : Directed + randomized key stimulus against a sliding-window model.
// Revision : 1.0
// ============================================================================
module tb_key_debounce;

    localparam int C_KN  = 4;
    localparam int C_DEB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [C_KN-1:0] key_in;
    logic [C_KN-1:0] key_state;
    logic [C_KN-1:0] key_press;
    logic [C_KN-1:0] key_release;
    logic [1:0]      key_code;
    logic            key_valid;

    key_debounce #(
        .KEY_NUM        (C_KN),
        .DEBOUNCE_CYCLES(C_DEB),
        .CNT_W          (5)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_code   (key_code),
        .key_valid  (key_valid)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: debounced level flips once the last DEB+1 synchronized
    // samples all disagree with it.
    bit [C_KN-1:0] m_state, m_press, m_release;
    bit [1:0]      m_code;
    bit            m_valid;
    bit [C_KN-1:0] m_d1, m_d2;
    bit [C_KN-1:0] m_win[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit [C_KN-1:0] fsm_in;
        bit [C_KN-1:0] prev_press;
        bit            all_diff;
        if (rst) begin
            m_state = '0; m_press = '0; m_release = '0;
            m_code = '0; m_valid = 1'b0;
            m_d1 = '0; m_d2 = '0;
            m_win.delete();
        end else begin
            fsm_in = m_d2;
            m_d2   = m_d1;
            m_d1   = ~key_in;
            prev_press = m_press;
            m_valid = (prev_press != '0);
            for (int k = C_KN - 1; k >= 0; k--)
                if (prev_press[k]) m_code = 2'(k);
            m_win.push_back(fsm_in);
            if (m_win.size() > C_DEB + 1) void'(m_win.pop_front());
            m_press = '0;
            m_release = '0;
            if (m_win.size() == C_DEB + 1) begin
                for (int k = 0; k < C_KN; k++) begin
                    all_diff = 1'b1;
                    foreach (m_win[w])
                        if (m_win[w][k] == m_state[k]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (m_state[k]) m_release[k] = 1'b1;
                        else            m_press[k]   = 1'b1;
                        m_state[k] = ~m_state[k];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("key_state",   8'(key_state),   8'(m_state));
        check("key_press",   8'(key_press),   8'(m_press));
        check("key_release", 8'(key_release), 8'(m_release));
        check("key_code",    8'(key_code),    8'(m_code));
        check("key_valid",   8'(key_valid),   8'(m_valid));
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    int remain[C_KN];

    initial begin
        rst    = 1'b1;
        key_in = '1;
        run(5);
        rst = 1'b0;
        run(45);

        // Clean press / release on key 2
        key_in[2] = 1'b0; run(30);
        key_in[2] = 1'b1; run(30);

        // Bounce on key 0, then settle pressed
        for (int t = 0; t < 8; t++) begin
            key_in[0] = t[0]; run(5);
        end
        key_in[0] = 1'b0; run(30);
        key_in[0] = 1'b1; run(30);

        // Simultaneous keys 3 and 1
        key_in = 4'b0101; run(30);
        key_in = 4'b1111; run(30);

        // Overlapping presses on keys 0 and 3
        key_in[0] = 1'b0; run(10);
        key_in[3] = 1'b0; run(30);
        key_in = 4'b1111; run(30);

        // Reset in the middle of a press filter, key kept held
        key_in[1] = 1'b0; run(10);
        rst = 1'b1; run(2);
        rst = 1'b0; run(30);
        key_in[1] = 1'b1; run(30);

        // Randomized bouncing on all keys with occasional resets
        foreach (remain[k]) remain[k] = $urandom_range(0, 40);
        for (int c = 0; c < 6000; c++) begin
            for (int k = 0; k < C_KN; k++) begin
                if (remain[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    remain[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                                            : $urandom_range(18, 60);
                end else begin
                    remain[k]--;
                end
            end
            rst = ($urandom_range(0, 999) == 0) || (rst && $urandom_range(0, 1) == 0);
            tick();
        end
        rst = 1'b0;
        key_in = '1;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
